// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared types and constants for the MIPS fetch/decode slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/mips_pc_next.sv
`default_nettype none
// ============================================================================
// Module      : mips_pc_next
// Description : Combinational next-PC selection (sequential, branch, jump).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_pc_next (
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        pcsrc,
    input  logic        jump,
    output logic [31:0] pc_next
);

    logic [31:0] w_pc4;
    logic [31:0] w_br_off;
    logic        w_unused;

    assign w_pc4    = pc + 32'd4;
    assign w_br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
    // Opcode field plays no part in target computation.
    assign w_unused = &{1'b0, instr[31:26]};

    // Jump outranks branch when the control unit raises both.
    always_comb begin
        pc_next = w_pc4;
        if (jump) begin
            pc_next = {w_pc4[31:28], instr[25:0], 2'b00};
        end else if (pcsrc) begin
            pc_next = w_pc4 + w_br_off;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_fetch_unit
// Description : Instruction fetch stage with req/ready memory handshake.
//               Optional retired-instruction counter: FETCH_INSTR_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic        instr_valid,
    input  logic        instr_ack,
    input  logic        pcsrc,
    input  logic        jump
`ifdef FETCH_INSTR_COUNT_EN
    ,
    output logic [31:0] instr_count
`endif
);

    localparam logic [31:0] c_reset_pc = {RESET_PC[31:2], 2'b00};

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  w_pc_next;
    logic         w_latch;
    logic         w_retire;

    assign w_latch  = (r_state == REQ)  && imem_ready;
    assign w_retire = (r_state == HOLD) && instr_ack;

    mips_pc_next u_pc_next (
        .pc      (r_pc),
        .instr   (r_instr),
        .pcsrc   (pcsrc),
        .jump    (jump),
        .pc_next (w_pc_next)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = REQ;
            REQ:     if (imem_ready) w_state_next = HOLD;
            HOLD:    if (instr_ack)  w_state_next = REQ;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_pc    <= c_reset_pc;
            r_instr <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) r_instr <= imem_rdata;
            if (w_retire) r_pc <= w_pc_next;
        end
    end

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= 32'd0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 32'd1;
        end
    end

    assign instr_count = r_instr_count;
`endif

    // Outputs decode registered state only; no input reaches an output.
    assign imem_req    = (r_state == REQ);
    assign instr_valid = (r_state == HOLD);
    assign imem_addr   = r_pc;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];

endmodule
`default_nettype wire

// File: tb/tb_mips_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_fetch_unit
// Description : Self-checking bench for mips_fetch_unit against a PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_fetch_unit;

    localparam longint c_two32 = 64'sh1_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic        instr_valid;
    logic        instr_ack;
    logic        pcsrc;
    logic        jump;
`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    mips_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .pc          (pc),
        .instr_valid (instr_valid),
        .instr_ack   (instr_ack),
        .pcsrc       (pcsrc),
        .jump        (jump)
`ifdef FETCH_INSTR_COUNT_EN
        ,
        .instr_count (instr_count)
`endif
    );

    // Next PC from the architectural rules using plain integer arithmetic.
    function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                             input logic br, input logic j);
        longint p4, imm, t;
        p4 = (longint'(cur) + 4) % c_two32;
        if (j) begin
            t = (p4 / 268435456) * 268435456 + longint'(ins[25:0]) * 4;
        end else if (br) begin
            imm = longint'(ins[15:0]);
            if (imm >= 32768) imm = imm - 65536;
            t = p4 + imm * 4;
            if (t < 0) t = t + c_two32;
            t = t % c_two32;
        end else begin
            t = p4;
        end
        return t[31:0];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] data, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            imem_ready = 1'b0;
            imem_rdata = $urandom;
            step();
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        step();
        imem_ready = 1'b0;
        imem_rdata = $urandom;
        m_instr    = data;
    endtask

    task automatic retire(input logic br, input logic j);
        instr_ack = 1'b1;
        pcsrc     = br;
        jump      = j;
        step();
        instr_ack = 1'b0;
        pcsrc     = 1'b0;
        jump      = 1'b0;
        m_pc      = ref_next(m_pc, m_instr, br, j);
        m_count   = m_count + 32'd1;
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        imem_ready = 1'b0;
        imem_rdata = 32'd0;
        instr_ack  = 1'b0;
        pcsrc      = 1'b0;
        jump       = 1'b0;
        step();
        step();
        m_pc    = 32'd0;
        m_instr = 32'd0;
        m_count = 32'd0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: req=%b valid=%b, want 0/0", imem_req, instr_valid);
        end
        n_cmp++;
        if (pc !== 32'd0 || instr !== 32'd0) begin
            n_err++;
            $display("FAIL reset_regs: pc=%h instr=%h, want 0/0", pc, instr);
        end
`ifdef FETCH_INSTR_COUNT_EN
        n_cmp++;
        if (instr_count !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d want 0", instr_count);
        end
`endif
    endtask

    task automatic test_fetch_seq();
        reset = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_cycle: req=%b valid=%b, want 0/0", imem_req, instr_valid);
        end
        step();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_err++;
            $display("FAIL first_req: req=%b addr=%h, want 1/0", imem_req, imem_addr);
        end
        fetch(32'h8C08_0004, 0);
        n_cmp++;
        if (instr_valid !== 1'b1 || op !== 6'b100011 || funct !== 6'b000100 || pc !== 32'd0) begin
            n_err++;
            $display("FAIL first_fetch: valid=%b op=%b funct=%b pc=%h, want 1/100011/000100/0",
                     instr_valid, op, funct, pc);
        end
        retire(1'b0, 1'b0);
        n_cmp++;
        if (imem_addr !== 32'h4 || imem_req !== 1'b1 || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL seq_step: req=%b addr=%h, want 1/00000004", imem_req, imem_addr);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 8 && m_pc != 32'h10; i++) begin
            fetch($urandom, int'($urandom_range(0, 1)));
            retire(1'b0, 1'b0);
        end
        fetch(32'h1000_0003, 0);
        n_cmp++;
        if (pc !== 32'h10) begin
            n_err++;
            $display("FAIL beq_pc: got %h want 00000010", pc);
        end
        retire(1'b1, 1'b0);
        n_cmp++;
        if (imem_addr !== 32'h20 || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL beq_fwd: got %h want 00000020", imem_addr);
        end
        fetch(32'h1000_FFFF, 0);
        retire(1'b1, 1'b0);
        n_cmp++;
        if (imem_addr !== 32'h20 || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL beq_back: got %h want 00000020", imem_addr);
        end
    endtask

    task automatic test_jump();
        fetch(32'h0BFF_FFFF, 0);
        retire(1'b0, 1'b1);
        n_cmp++;
        if (imem_addr !== 32'h0FFF_FFFC || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL jump_far: got %h want 0ffffffc", imem_addr);
        end
        fetch($urandom, 0);
        retire(1'b0, 1'b0);
        fetch(32'h0800_0040, 0);
        n_cmp++;
        if (pc !== 32'h1000_0000) begin
            n_err++;
            $display("FAIL jump_pc: got %h want 10000000", pc);
        end
        retire(1'b1, 1'b1);
        n_cmp++;
        if (imem_addr !== 32'h1000_0100 || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL jump_prio: got %h want 10000100", imem_addr);
        end
    endtask

    task automatic test_stall();
        logic [31:0] data;
        data = $urandom;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== m_pc || instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL stall_%0d: req=%b addr=%h valid=%b, want 1/%h/0",
                         i, imem_req, imem_addr, instr_valid, m_pc);
            end
            imem_ready = 1'b0;
            imem_rdata = ~data;
            step();
        end
        fetch(data, 0);
        n_cmp++;
        if (instr_valid !== 1'b1 || instr !== data) begin
            n_err++;
            $display("FAIL stall_latch: valid=%b instr=%h, want 1/%h", instr_valid, instr, data);
        end
        retire(1'b0, 1'b0);
    endtask

    task automatic test_ack_held();
        logic [31:0] data;
        data      = $urandom;
        instr_ack = 1'b1;
        pcsrc     = 1'b1;
        jump      = 1'b1;
        imem_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if (pc !== m_pc || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL ack_in_req: pc=%h req=%b, want %h/1", pc, imem_req, m_pc);
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        step();
        m_instr    = data;
        imem_rdata = ~data;
        step();
        imem_ready = 1'b0;
        m_pc       = ref_next(m_pc, m_instr, 1'b1, 1'b1);
        m_count    = m_count + 32'd1;
        n_cmp++;
        if (imem_addr !== m_pc || instr !== data) begin
            n_err++;
            $display("FAIL ack_once: addr=%h instr=%h, want %h/%h", imem_addr, instr, m_pc, data);
        end
        step();
        instr_ack = 1'b0;
        pcsrc     = 1'b0;
        jump      = 1'b0;
        n_cmp++;
        if (pc !== m_pc || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL ack_no_double: pc=%h req=%b, want %h/1", pc, imem_req, m_pc);
        end
`ifdef FETCH_INSTR_COUNT_EN
        n_cmp++;
        if (instr_count !== m_count) begin
            n_err++;
            $display("FAIL ack_count: got %0d want %0d", instr_count, m_count);
        end
`endif
    endtask

    task automatic test_reset_mid();
        fetch($urandom | 32'h1, 0);
        instr_ack = 1'b1;
        reset     = 1'b1;
        step();
        instr_ack = 1'b0;
        m_pc = 32'd0; m_instr = 32'd0; m_count = 32'd0;
        n_cmp++;
        if (instr_valid !== 1'b0 || pc !== 32'd0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_hold: valid=%b pc=%h req=%b, want 0/0/0", instr_valid, pc, imem_req);
        end
        reset = 1'b0;
        step();
        imem_ready = 1'b1;
        imem_rdata = $urandom | 32'h1;
        reset      = 1'b1;
        step();
        imem_ready = 1'b0;
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== 32'd0 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL rst_req: valid=%b instr=%h req=%b, want 0/0/0", instr_valid, instr, imem_req);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        fetch(32'h1000_FFFE, 0);
        retire(1'b1, 1'b0);
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL wrap_back: got %h want fffffffc", imem_addr);
        end
        fetch($urandom, 1);
        retire(1'b0, 1'b0);
        n_cmp++;
        if (imem_addr !== 32'h0 || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL wrap_zero: got %h want 00000000", imem_addr);
        end
    endtask

    task automatic test_random();
        logic [31:0] data;
        for (int i = 0; i < 40; i++) begin
            data = $urandom;
            fetch(data, int'($urandom_range(0, 3)));
            n_cmp++;
            if (instr !== data || pc !== m_pc || op !== data[31:26] || funct !== data[5:0]) begin
                n_err++;
                $display("FAIL rnd_fetch_%0d: instr=%h pc=%h, want %h/%h", i, instr, pc, data, m_pc);
            end
            retire(1'($urandom), 1'($urandom));
            n_cmp++;
            if (imem_addr !== m_pc || imem_req !== 1'b1) begin
                n_err++;
                $display("FAIL rnd_next_%0d: addr=%h req=%b, want %h/1", i, imem_addr, imem_req, m_pc);
            end
        end
`ifdef FETCH_INSTR_COUNT_EN
        n_cmp++;
        if (instr_count !== m_count) begin
            n_err++;
            $display("FAIL rnd_count: got %0d want %0d", instr_count, m_count);
        end
`endif
    endtask

    task automatic test_count();
        apply_reset();
        reset = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            fetch($urandom, int'($urandom_range(0, 2)));
            retire(1'b0, 1'b0);
        end
        n_cmp++;
        if (m_pc !== 32'd20 || imem_addr !== m_pc) begin
            n_err++;
            $display("FAIL five_seq_addr: got %h want 00000014", imem_addr);
        end
`ifdef FETCH_INSTR_COUNT_EN
        n_cmp++;
        if (instr_count !== 32'd5) begin
            n_err++;
            $display("FAIL five_count: got %0d want 5", instr_count);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_branch();
        test_jump();
        test_stall();
        test_ack_held();
        test_reset_mid();
        test_wrap();
        test_random();
        test_count();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_fetch_unit.md
# mips_fetch_unit

Instruction fetch stage for the single-cycle MIPS core. Owns the program counter, fetches one 32-bit word per instruction from instruction memory over a req/ready handshake, and presents the held instruction (with `op`/`funct` split out) to `control_unity` and the datapath. Consumes `control_unity`'s `pcsrc` and `jump` outputs to compute the next PC. Also inserts wait states when memory is slow.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous reset, active-high
- `imem_req`  out  1  fetch request; held high until `imem_ready`
- `imem_addr`  out  32  fetch address (= `pc`); bits [1:0] always 0
- `imem_ready`  in  1  memory accepts the request and `imem_rdata` is valid this cycle
- `imem_rdata`  in  32  instruction word
- `instr`  out  32  held instruction
- `op`  out  6  `instr[31:26]`
- `funct`  out  6  `instr[5:0]`
- `pc`  out  32  address of the held instruction
- `instr_valid`  out  1  `instr`/`op`/`funct`/`pc` are valid
- `instr_ack`  in  1  datapath retires the held instruction this cycle
- `pcsrc`  in  1  take the branch; sampled only with `instr_ack`
- `jump`  in  1  take the jump; sampled only with `instr_ack`
- `instr_count`  out  32  retired-instruction counter (present only with `FETCH_INSTR_COUNT_EN`)

## Operation
- FSM states: IDLE, REQ, HOLD.
- IDLE: entered on reset. `imem_req`=0, `instr_valid`=0. Goes unconditionally to REQ on the first cycle with `reset` low.
- REQ: `imem_req`=1 and `imem_addr`=`pc`. On `imem_ready`=1, latch `imem_rdata` into `instr` and go to HOLD. Otherwise stay in REQ with the address held stable.
- HOLD: `instr_valid`=1 and `instr` is frozen. On `instr_ack`=1, load the next PC and go to REQ. Otherwise stay in HOLD.
- Next PC, with `pc4` = `pc` + 4 (mod 2^32):
  - `jump`=1: {`pc4[31:28]`, `instr[25:0]`, 2'b00}.
  - else `pcsrc`=1: `pc4` + (sign-extended `instr[15:0]` << 2), mod 2^32.
  - else: `pc4`.
- `jump` has priority over `pcsrc` when both are high.
- `instr_ack` outside HOLD is ignored. `imem_ready` outside REQ is ignored, and `imem_rdata` is not latched.
- Reset values: state=IDLE, `pc`=`RESET_PC`, `instr`=0, `instr_valid`=0, `imem_req`=0, `instr_count`=0.
- Reset in any state, including mid-request or while HOLD is waiting for ack, aborts the operation. Next cycle: IDLE, `pc`=`RESET_PC`, no latch. A `imem_ready` arriving in the reset cycle is discarded.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from input to output.
- Minimum 2 cycles per instruction: REQ with same-cycle `imem_ready`, then HOLD with same-cycle `instr_ack`.
- `instr_valid` rises the cycle after the `imem_ready` handshake.
- `pc` and `imem_addr` take the new value the cycle after `instr_ack`, and `imem_req` is high in that same cycle.
- Each cycle `imem_ready` stays low in REQ adds one cycle of latency.
- `instr_ack` may be held high continuously; exactly one retirement occurs per HOLD visit.

## Configuration
- `FETCH_INSTR_COUNT_EN` defined: adds the `instr_count` port.
  - Increments by 1 on each HOLD-state `instr_ack`.
  - Wraps 0xFFFF_FFFF→0.
  - Cleared by reset.
- `FETCH_INSTR_COUNT_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `mips_pkg` holds:
  - FSM state enum (IDLE/REQ/HOLD).
  - Opcode constants: OP_RTYPE 6'b000000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_ADDI 6'b001000, OP_J 6'b000010.
  - Default reset PC constant.
- One combinational sub-module, `mips_pc_next`: inputs `pc`, `instr`, `pcsrc`, `jump`; output next PC. Reusable by a future multicycle core.

## Test plan
- Fetch and sequential step: reset with `RESET_PC`=0, release → IDLE one cycle, then `imem_req`=1, `imem_addr`=0. Drive `imem_ready`=1 with `imem_rdata`=0x8C08_0004 → next cycle `instr_valid`=1, `op`=6'b100011, `funct`=6'b000100. Ack with `pcsrc`=0, `jump`=0 → `imem_addr`=0x4.
- Branch taken, forward and backward: `beq` 0x1000_0003 at `pc`=0x10, ack with `pcsrc`=1 → next PC 0x20. Imm 0xFFFF at `pc`=0x20 → next PC 0x20.
- Jump and priority: `instr`=0x0800_0040 at `pc`=0x1000_0000, ack with `jump`=1 and `pcsrc`=1 → next PC 0x1000_0100 (jump wins).
- Memory stall: hold `imem_ready`=0 for 3 cycles in REQ → `imem_req`=1 and `imem_addr` stable throughout, `instr_valid`=0. On the 4th cycle `imem_ready`=1 → latched.
- Reset mid-operation: assert `reset` in HOLD with `instr_ack`=1 → next cycle `instr_valid`=0, `pc`=`RESET_PC`, no PC advance. Same test in REQ with `imem_ready`=1 → nothing latched.
- Wrap and count: `pc`=0xFFFF_FFFC, ack with no branch → next PC 0x0. With `FETCH_INSTR_COUNT_EN`, 5 retirements → `instr_count`=5, and `instr_ack` held high through stalls counts once per instruction.
